// File: rtl/fm_pingpong_ctrl.sv
// fm_pingpong_ctrl: ownership and address sequencer for the FM multi-buffer
// store. The producer fills buffers in round-robin order, one 8-base row per
// accepted beat, while the extender claims and releases completed buffers in
// the same order. Each buffer cycles EMPTY -> FILLING -> FULL -> READING.
module fm_pingpong_ctrl #(
  parameter int FM_BUFFER_COUNT  = 2,
  parameter int FM_RAMS_COUNT    = 8,
  parameter int FM_ENTRIES_COUNT = 8,
  parameter int FM_OFFSET_COUNT  = 2,
  parameter int BASE_LEN         = 2,
  parameter int FRAG_LEN         = 8,
  localparam int ROWS       = FM_ENTRIES_COUNT * FM_OFFSET_COUNT,
  localparam int ROW_W      = $clog2(ROWS),
  localparam int BUF_W      = $clog2(FM_BUFFER_COUNT),
  localparam int INDICE_LEN = $clog2(ROWS * FRAG_LEN),
  localparam int LEN_W      = INDICE_LEN + 1,
  localparam int FRAG_W     = BASE_LEN * FRAG_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [FRAG_W-1:0] wr_frag,
  input  logic              wr_last,
  output logic              mem_wr_en,
  output logic [BUF_W-1:0]  mem_wr_buf,
  output logic [ROW_W-1:0]  mem_wr_row,
  output logic [FRAG_W-1:0] mem_wr_data,
  output logic              rd_avail,
  output logic [BUF_W-1:0]  rd_buf,
  output logic [LEN_W-1:0]  rd_len,
  input  logic              rd_take,
  input  logic              rd_done,
  output logic [BUF_W:0]    full_count
);

  typedef enum logic [1:0] {
    BUF_EMPTY,
    BUF_FILLING,
    BUF_FULL,
    BUF_READING
  } buf_state_e;

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [BUF_W-1:0] PTR_LAST = BUF_W'(FM_BUFFER_COUNT - 1);

  buf_state_e        state_q [FM_BUFFER_COUNT];
  buf_state_e        state_d [FM_BUFFER_COUNT];
  logic [LEN_W-1:0]  len_q   [FM_BUFFER_COUNT];
  logic [LEN_W-1:0]  len_d   [FM_BUFFER_COUNT];
  logic [BUF_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [BUF_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [BUF_W:0]    full_count_q, full_count_d;

  logic              wr_en_q;
  logic [BUF_W-1:0]  wr_buf_q;
  logic [ROW_W-1:0]  wr_row_q;
  logic [FRAG_W-1:0] wr_data_q;

  logic accept;
  logic close;
  logic wr_open;

  function automatic logic [BUF_W-1:0] ptr_next(input logic [BUF_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Write-side handshake; held low while reset is asserted so the
  // producer sees ready only from the first cycle after reset.
  always_comb begin
    wr_open  = (state_q[wr_ptr_q] == BUF_EMPTY) || (state_q[wr_ptr_q] == BUF_FILLING);
    wr_ready = wr_open & ~rst;
    accept   = wr_valid & wr_ready;
    close    = accept & (wr_last | (row_q == ROW_LAST));
  end

  // Next buffer states, lengths, pointers and row counter. Writer and reader
  // can never touch the same buffer in one cycle, so both updates apply.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    row_d    = row_q;

    if (accept) begin
      if (close) begin
        state_d[wr_ptr_q] = BUF_FULL;
        len_d[wr_ptr_q]   = (LEN_W'(row_q) + LEN_W'(1)) * LEN_W'(FM_RAMS_COUNT);
        row_d             = '0;
        wr_ptr_d          = ptr_next(wr_ptr_q);
      end else begin
        state_d[wr_ptr_q] = BUF_FILLING;
        row_d             = row_q + 1'b1;
      end
    end

    if (rd_done && (state_q[rd_ptr_q] == BUF_READING)) begin
      state_d[rd_ptr_q] = BUF_EMPTY;
      len_d[rd_ptr_q]   = '0;
      rd_ptr_d          = ptr_next(rd_ptr_q);
    end else if (rd_take && (state_q[rd_ptr_q] == BUF_FULL)) begin
      state_d[rd_ptr_q] = BUF_READING;
    end
  end

  // Occupancy of the current state; registered so it trails by one cycle.
  always_comb begin
    full_count_d = '0;
    for (int unsigned i = 0; i < FM_BUFFER_COUNT; i++) begin
      if ((state_q[i] == BUF_FULL) || (state_q[i] == BUF_READING)) begin
        full_count_d = full_count_d + 1'b1;
      end
    end
  end

  // Buffer ownership state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < FM_BUFFER_COUNT; i++) begin
        state_q[i] <= BUF_EMPTY;
        len_q[i]   <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      row_q        <= '0;
      full_count_q <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      row_q        <= row_d;
      full_count_q <= full_count_d;
    end
  end

  // RAM write port: one registered strobe per accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_buf_q  <= '0;
      wr_row_q  <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= accept;
      if (accept) begin
        wr_buf_q  <= wr_ptr_q;
        wr_row_q  <= row_q;
        wr_data_q <= wr_frag;
      end
    end
  end

  // Output mapping.
  always_comb begin
    mem_wr_en   = wr_en_q;
    mem_wr_buf  = wr_buf_q;
    mem_wr_row  = wr_row_q;
    mem_wr_data = wr_data_q;
    rd_avail    = (state_q[rd_ptr_q] == BUF_FULL);
    rd_buf      = rd_ptr_q;
    rd_len      = len_q[rd_ptr_q];
    full_count  = full_count_q;
  end

endmodule
